fcs_tx_controller: RTL and testbench
====================================

FCS_TX_CONTROLLER -- requirements
Module: fcs_tx_controller

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum frame bytes (excluding FCS) when padding is compiled in.
REQ-002 SHALL have parameter CNT_W, default 11, width of the frame byte counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_data  input  8, in_valid  input  1, in_last  input  1, in_ready  output  1  upstream frame byte stream.
REQ-006 SHALL have ports out_data  output  8, out_valid  output  1, out_last  output  1, out_ready  input  1  downstream stream: frame, then FCS.
REQ-007 SHALL have ports crc_clr  output  1, crc_en  output  1, crc_data  output  8  drive the external CRC-32 engine.
REQ-008 SHALL have port crc_in  input  32  engine register value.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement states IDLE, DATA, PAD, CRCW, FCS.
REQ-011 Engine contract: crc_clr loads 0xFFFFFFFF; crc_en folds crc_data into the register (reflected CRC-32); crc_in reflects the update on the next cycle.
REQ-012 IDLE: in_ready=0, out_valid=0; when in_valid=1, crc_clr=1 for that cycle and next state is DATA.
REQ-013 DATA: out_data=in_data, out_valid=in_valid, in_ready=out_ready, crc_data=in_data, crc_en=in_valid&out_ready (all combinational, zero latency); out_last=0.
REQ-014 DATA: each transfer increments the byte counter, which saturates at 2^CNT_W-1.
REQ-015 DATA: a transfer with in_last=1 goes to PAD if padding is compiled in and the count including this byte is below MIN_FRAME; otherwise it goes to CRCW.
REQ-016 PAD: out_valid=1, out_data=0x00, crc_data=0x00, crc_en=out_ready, in_ready=0; each accepted byte increments the counter; exit to CRCW on the transfer that brings the count to MIN_FRAME.
REQ-017 CRCW: exactly one cycle with out_valid=0 and in_ready=0; register fcs = crc_in XOR 0xFFFFFFFF; next state is FCS with index 0.
REQ-018 FCS: out_valid=1, out_data=fcs byte[index] LSB-byte first (index 0 = fcs[7:0]), out_last=1 only at index 3; index advances only when out_ready=1; a transfer at index 3 returns the block to IDLE and clears the counter.
REQ-019 out_ready=0 in any state SHALL hold out_data, index and counter stable with crc_en=0.
REQ-020 in_last on the first byte of a frame is legal (1-byte frame).
REQ-021 in_valid during PAD, CRCW or FCS SHALL be ignored (in_ready=0); the next frame starts only from IDLE.
REQ-022 crc_clr and crc_en SHALL never be high in the same cycle.

Reset
REQ-023 Reset SHALL set state=IDLE, counter=0, index=0, fcs=0, in_ready=0, out_valid=0, out_last=0, out_data=0, crc_clr=0, crc_en=0, busy=0.
REQ-024 Reset mid-frame SHALL abort without emitting out_last or FCS bytes; the next frame starts cleanly with crc_clr.

Configuration
REQ-025 Macro FCS_TX_PAD_EN: when defined, PAD state and MIN_FRAME padding are compiled in.
REQ-026 Without FCS_TX_PAD_EN, PAD logic SHALL be absent; in_last in DATA always leads to CRCW; MIN_FRAME SHALL be unused.

Structure
REQ-027 Shared package fcs_tx_pkg SHALL hold the state enum, CRC_INIT=0xFFFFFFFF, CRC_XOROUT=0xFFFFFFFF and default MIN_FRAME.
REQ-028 SHALL be a single module with no sub-module; the CRC engine is instantiated by the parent.

Verification (bench uses a behavioural reflected CRC-32 engine)
REQ-029 Frame ASCII "123456789" (9 bytes), padding out, out_ready=1 -> 9 data beats, 1 idle cycle, then FCS 0x26,0x39,0xF4,0xCB with out_last on 0xCB.
REQ-030 Same frame with FCS_TX_PAD_EN, MIN_FRAME=60 -> 60 data beats (bytes 10..60 = 0x00), then 4 FCS bytes matching the CRC of the padded 60 bytes; total 64 valid beats.
REQ-031 1-byte frame 0x00, padding out -> 1 data beat, then FCS 0x8D,0xEF,0x02,0xD2.
REQ-032 Toggle out_ready 1-0-1 every cycle through a 9-byte frame -> output identical to REQ-029; crc_en is high only on accepted beats.
REQ-033 Assert rst during the 5th data byte, then send "123456789" -> no out_last before the new frame; FCS matches REQ-029.
REQ-034 Back-to-back frames with in_valid held high -> in_ready=0 through CRCW/FCS; crc_clr pulses once per frame in IDLE; both FCS values are correct.

Source files
------------

// File: rtl/fcs_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fcs_tx_pkg
// Description : Shared state encoding and CRC-32 constants for fcs_tx_controller
// Revision    : 1.0 - initial release
// ============================================================================
package fcs_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_PAD  = 3'd2,
        ST_CRCW = 3'd3,
        ST_FCS  = 3'd4
    } fcs_state_t;

    localparam logic [31:0] CRC_INIT          = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT        = 32'hFFFF_FFFF;
    localparam int          MIN_FRAME_DEFAULT = 60;

endpackage
`default_nettype wire

// File: rtl/fcs_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : fcs_tx_controller
// Description : Passes a frame through, steers an external CRC-32 engine and
//               appends the 4-byte FCS. Define FCS_TX_PAD_EN for zero padding
//               up to MIN_FRAME bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module fcs_tx_controller
    import fcs_tx_pkg::*;
#(
    parameter int MIN_FRAME = MIN_FRAME_DEFAULT,
    parameter int CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        crc_clr,
    output logic        crc_en,
    output logic [7:0]  crc_data,
    input  logic [31:0] crc_in,
    output logic        busy
);

    fcs_state_t         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]         r_idx, w_idx_nxt;
    logic [31:0]        r_fcs, w_fcs_nxt;
    logic [7:0]         w_fcs_byte;

`ifdef FCS_TX_PAD_EN
    localparam logic [CNT_W-1:0] c_min_frame = CNT_W'(MIN_FRAME);
`endif

    // Saturating so an oversize frame can never wrap into a short-frame count
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        case (r_idx)
            2'd0:    w_fcs_byte = r_fcs[7:0];
            2'd1:    w_fcs_byte = r_fcs[15:8];
            2'd2:    w_fcs_byte = r_fcs[23:16];
            default: w_fcs_byte = r_fcs[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_fcs   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_fcs   <= w_fcs_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_fcs_nxt   = r_fcs;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = 8'h00;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_data    = 8'h00;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    crc_clr     = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                out_data  = in_data;
                out_valid = in_valid;
                in_ready  = out_ready;
                crc_data  = in_data;
                crc_en    = in_valid & out_ready;
                if (in_valid && out_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (in_last) begin
`ifdef FCS_TX_PAD_EN
                        w_state_nxt = (w_cnt_inc < c_min_frame) ? ST_PAD : ST_CRCW;
`else
                        w_state_nxt = ST_CRCW;
`endif
                    end
                end
            end

`ifdef FCS_TX_PAD_EN
            ST_PAD: begin
                out_valid = 1'b1;
                crc_en    = out_ready;
                if (out_ready) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_min_frame) begin
                        w_state_nxt = ST_CRCW;
                    end
                end
            end
`endif

            // Engine register now holds the last folded byte
            ST_CRCW: begin
                w_fcs_nxt   = crc_in ^ CRC_XOROUT;
                w_idx_nxt   = 2'd0;
                w_state_nxt = ST_FCS;
            end

            ST_FCS: begin
                out_valid = 1'b1;
                out_data  = w_fcs_byte;
                out_last  = (r_idx == 2'd3);
                if (out_ready) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_idx_nxt   = 2'd0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        // Outputs are quiet while reset is held, whatever state is registered
        if (rst) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_last  = 1'b0;
            out_data  = 8'h00;
            crc_clr   = 1'b0;
            crc_en    = 1'b0;
            crc_data  = 8'h00;
        end
    end

    assign busy = (r_state != ST_IDLE) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_fcs_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fcs_tx_controller
// Description : Directed self-checking bench for fcs_tx_controller with a
//               behavioural reflected CRC-32 engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fcs_tx_controller;
    import fcs_tx_pkg::*;

    localparam int c_min_frame = 60;
    localparam int K_DATA = 0, K_PAD = 1, K_FCS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready;
    logic        crc_clr, crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_reg;
    logic        busy;

    fcs_tx_controller #(.MIN_FRAME(c_min_frame), .CNT_W(11)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .crc_clr(crc_clr), .crc_en(crc_en), .crc_data(crc_data), .crc_in(crc_reg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    always @(posedge clk) begin
        if (crc_clr)     crc_reg <= CRC_INIT;
        else if (crc_en) crc_reg <= crc_step(crc_reg, crc_data);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Stimulus stream, expected beats and captured beats
    logic [7:0]  stim_d[$];
    bit          stim_l[$];
    int          flen[$];
    logic [7:0]  exp_d[$];
    bit          exp_l[$];
    int          exp_k[$];
    logic [7:0]  got_d[$];
    bit          got_l[$];
    logic [31:0] got_fcs[$];
    int          last_nclr;

    task automatic clear_stream();
        stim_d.delete(); stim_l.delete(); flen.delete();
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            stim_d.push_back(s[i]);
            stim_l.push_back(i == s.len() - 1);
        end
        flen.push_back(s.len());
    endtask

    task automatic add_byte_frame(input logic [7:0] b);
        stim_d.push_back(b);
        stim_l.push_back(1'b1);
        flen.push_back(1);
    endtask

    task automatic build_expected();
        int base = 0;
        exp_d.delete(); exp_l.delete(); exp_k.delete();
        foreach (flen[f]) begin
            logic [31:0] c;
            int n;
            c = 32'hFFFF_FFFF;
            n = flen[f];
            for (int i = 0; i < n; i++) begin
                exp_d.push_back(stim_d[base + i]); exp_l.push_back(1'b0); exp_k.push_back(K_DATA);
                c = crc_step(c, stim_d[base + i]);
            end
`ifdef FCS_TX_PAD_EN
            for (int i = n; i < c_min_frame; i++) begin
                exp_d.push_back(8'h00); exp_l.push_back(1'b0); exp_k.push_back(K_PAD);
                c = crc_step(c, 8'h00);
            end
`endif
            c = ~c;
            for (int i = 0; i < 4; i++) begin
                exp_d.push_back(c[8*i +: 8]); exp_l.push_back(i == 3); exp_k.push_back(K_FCS);
            end
            base += n;
        end
    endtask

    task automatic run(input string name, input int nfr, input bit toggle);
        int pos = 0, si = 0, cyc = 0, nlast = 0, nclr = 0, bad_en = 0, bad_rdy = 0;
        logic [31:0] fw = '0;
        build_expected();
        got_d.delete(); got_l.delete(); got_fcs.delete();
        while (nlast < nfr && cyc < 3000) begin
            @(negedge clk);
            in_valid  = (si < stim_d.size());
            in_data   = in_valid ? stim_d[si] : 8'h00;
            in_last   = in_valid ? stim_l[si] : 1'b0;
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (crc_clr) nclr++;
            if (crc_clr && crc_en) bad_en++;
            if (pos < exp_k.size()) begin
                if (crc_en !== (out_valid && out_ready && exp_k[pos] != K_FCS)) bad_en++;
                if (in_ready && exp_k[pos] != K_DATA) bad_rdy++;
            end
            if (in_valid && in_ready) si++;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                fw = {out_data, fw[31:8]};
                pos++;
                if (out_last) begin
                    nlast++;
                    got_fcs.push_back(fw);
                end
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        check({name, "_frames_done"}, 64'(nlast), 64'(nfr));
        check({name, "_beats"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
            check($sformatf("%s_beat%0d", name, i), {got_l[i], got_d[i]}, {exp_l[i], exp_d[i]});
        check({name, "_crc_clr_pulses"}, 64'(nclr), 64'(nfr));
        check({name, "_crc_en_gating"}, 64'(bad_en), 64'd0);
        check({name, "_in_ready_gating"}, 64'(bad_rdy), 64'd0);
        check({name, "_stim_consumed"}, 64'(si), 64'(stim_d.size()));
        last_nclr = nclr;
    endtask

    typedef struct {
        logic       iv;
        logic       il;
        logic [7:0] id;
        logic       ordy;
        logic [13:0] exp;   // {out_valid, out_last, out_data, in_ready, crc_clr, crc_en, busy}
    } vec_t;

    initial begin
        vec_t vecs[11];
        int   si, saw_last, guard;
        string s;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        check("reset_outputs", {out_valid, out_last, out_data, in_ready, crc_clr, crc_en, busy, crc_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("idle_after_reset", {out_valid, out_last, out_data, in_ready, crc_clr, crc_en, busy}, 64'd0);

`ifndef FCS_TX_PAD_EN
        // 1-byte frame 0x00 with a stall inside the FCS, one cycle per row
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{1'b1, 1'b1, 8'h00, 1'b1, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[2]  = '{1'b1, 1'b1, 8'h00, 1'b1, {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[3]  = '{1'b1, 1'b0, 8'hA5, 1'b1, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[4]  = '{1'b1, 1'b0, 8'hA5, 1'b1, {1'b1, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[5]  = '{1'b1, 1'b0, 8'hA5, 1'b0, {1'b1, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{1'b1, 1'b0, 8'hA5, 1'b1, {1'b1, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, {1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, {1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, {1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv; in_last = vecs[i].il; in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d", i), {out_valid, out_last, out_data, in_ready, crc_clr, crc_en, busy}, vecs[i].exp);
        end
`endif

        clear_stream(); add_str("123456789");
        run("frame9", 1, 1'b0);
`ifndef FCS_TX_PAD_EN
        check("frame9_fcs", (got_fcs.size() > 0) ? got_fcs[0] : 32'h0, 32'hCBF4_3926);
`endif

        clear_stream(); add_byte_frame(8'h00);
        run("frame1", 1, 1'b0);
`ifndef FCS_TX_PAD_EN
        check("frame1_fcs", (got_fcs.size() > 0) ? got_fcs[0] : 32'h0, 32'hD202_EF8D);
`endif

        clear_stream(); add_str("123456789");
        run("toggle", 1, 1'b1);
`ifndef FCS_TX_PAD_EN
        check("toggle_fcs", (got_fcs.size() > 0) ? got_fcs[0] : 32'h0, 32'hCBF4_3926);
`endif

        // Abort on the 5th data byte, then a clean frame
        s = "123456789"; si = 0; saw_last = 0; guard = 0;
        while (si < 4 && guard < 50) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = s[si]; in_last = 1'b0; out_ready = 1'b1;
            #1;
            if (out_last) saw_last++;
            if (in_ready) si++;
            guard++;
        end
        check("abort_reached_byte5", 64'(si), 64'd4);
        @(negedge clk);
        in_data = s[4]; rst = 1'b1;
        #1;
        if (out_last) saw_last++;
        check("abort_outputs_in_reset", {out_valid, in_ready, crc_en, crc_clr, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        if (out_last) saw_last++;
        check("abort_idle", {busy, out_valid, in_ready}, 64'd0);
        check("abort_no_last", 64'(saw_last), 64'd0);
        clear_stream(); add_str("123456789");
        run("after_abort", 1, 1'b0);
`ifndef FCS_TX_PAD_EN
        check("after_abort_fcs", (got_fcs.size() > 0) ? got_fcs[0] : 32'h0, 32'hCBF4_3926);
`endif

        clear_stream(); add_str("123456789"); add_str("123456789");
        run("b2b", 2, 1'b0);
`ifndef FCS_TX_PAD_EN
        check("b2b_fcs0", (got_fcs.size() > 0) ? got_fcs[0] : 32'h0, 32'hCBF4_3926);
        check("b2b_fcs1", (got_fcs.size() > 1) ? got_fcs[1] : 32'h0, 32'hCBF4_3926);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
